// File: rtl/vga_timing.sv
// vga_timing: pixel-stream source with VGA counters, syncs, blanks and markers.
// Default timing is 1024x768@60 (65 MHz pclk), VESA XGA negative syncs.
//
// Ports:
//   pclk        in   pixel clock, rising edge
//   rst         in   synchronous reset, active-low
//   en          in   count enable; all outputs hold while low
//   hcount_out  out  [10:0] horizontal position
//   vcount_out  out  [10:0] vertical position
//   hsync_out   out  horizontal sync, active level SYNC_POL
//   vsync_out   out  vertical sync, active level SYNC_POL
//   hblnk_out   out  horizontal blank, active-high
//   vblnk_out   out  vertical blank, active-high
//   line_start  out  high while hcount_out == 0
//   frame_start out  high while hcount_out == 0 and vcount_out == 0
//   frame_cnt   out  [15:0] frame counter (only with VGA_TIMING_FRAME_CNT_EN)
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module vga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        run_q,   run_d;
  logic [10:0] hcnt_q,  hcnt_d;
  logic [10:0] vcnt_q,  vcnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        lstr_q,  lstr_d;
  logic        fstr_q,  fstr_d;
  logic        wrap_h;
  logic        wrap_v;

  // run_q is clear right after reset: the first enabled edge
  // loads pixel (0,0) with both markers instead of advancing.
  always_comb begin
    run_d   = run_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    hblnk_d = hblnk_q;
    vblnk_d = vblnk_q;
    lstr_d  = lstr_q;
    fstr_d  = fstr_q;
    wrap_h  = (hcnt_q == H_LAST);
    wrap_v  = (vcnt_q == V_LAST);
    if (en) begin
      run_d = 1'b1;
      if (!run_q) begin
        hcnt_d = '0;
        vcnt_d = '0;
      end else if (wrap_h) begin
        hcnt_d = '0;
        vcnt_d = wrap_v ? '0 : vcnt_q + 11'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
      // decode from next-state so all outputs align with the counters
      hblnk_d = (hcnt_d >= H_ACT);
      vblnk_d = (vcnt_d >= V_ACT);
      hsync_d = (hcnt_d >= HS_BEG && hcnt_d < HS_END)
              ? SYNC_POL : ~SYNC_POL;
      vsync_d = (vcnt_d >= VS_BEG && vcnt_d < VS_END)
              ? SYNC_POL : ~SYNC_POL;
      lstr_d  = (hcnt_d == '0);
      fstr_d  = (hcnt_d == '0) && (vcnt_d == '0);
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      run_q   <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      lstr_q  <= 1'b0;
      fstr_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      lstr_q  <= lstr_d;
      fstr_q  <= fstr_d;
    end
  end

  assign hcount_out  = hcnt_q;
  assign vcount_out  = vcnt_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign hblnk_out   = hblnk_q;
  assign vblnk_out   = vblnk_q;
  assign line_start  = lstr_q;
  assign frame_start = fstr_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // counts true frame wraps only, not the initial load after reset
  always_comb begin
    fcnt_d = fcnt_q;
    if (en && run_q && wrap_h && wrap_v) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed vector bench for vga_timing.
// Default-timing instance plus a small-timing instance for frame-level cases.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst, d_en;
  logic [10:0] d_h, d_v;
  logic        d_hs, d_vs, d_hb, d_vb, d_ls, d_fs;

  logic        s_rst, s_en;
  logic [10:0] s_h, s_v;
  logic        s_hs, s_vs, s_hb, s_vb, s_ls, s_fs;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_cnt, s_cnt;
`endif

  vga_timing dut (
    .pclk(clk), .rst(d_rst), .en(d_en),
    .hcount_out(d_h), .vcount_out(d_v),
    .hsync_out(d_hs), .vsync_out(d_vs),
    .hblnk_out(d_hb), .vblnk_out(d_vb),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_cnt)
`endif
  );

  // H: 16+2+3+4 = 25, V: 6+1+2+2 = 11, frame = 275, active-high syncs
  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1)
  ) sdut (
    .pclk(clk), .rst(s_rst), .en(s_en),
    .hcount_out(s_h), .vcount_out(s_v),
    .hsync_out(s_hs), .vsync_out(s_vs),
    .hblnk_out(s_hb), .vblnk_out(s_vb),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_cnt)
`endif
  );

  typedef struct {
    string       nm;
    logic        rst;
    logic        en;
    int          n;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb, ls, fs;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nbad = 0;

  task automatic add(input string nm, input logic r, input logic e,
                     input int n, input int h, input int v,
                     input logic hs, input logic vs, input logic hb,
                     input logic vb, input logic ls, input logic fs);
    vec_t t;
    t.nm = nm; t.rst = r; t.en = e; t.n = n;
    t.h = 11'(h); t.v = 11'(v);
    t.hs = hs; t.vs = vs; t.hb = hb; t.vb = vb; t.ls = ls; t.fs = fs;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [27:0] pack(input logic [10:0] h,
      input logic [10:0] v, input logic hs, input logic vs,
      input logic hb, input logic vb, input logic ls, input logic fs);
    return {h, v, hs, vs, hb, vb, ls, fs};
  endfunction

  task automatic chk_s(input string nm, input int h, input int v,
                       input logic hs, input logic vs, input logic hb,
                       input logic vb, input logic ls, input logic fs);
    logic [27:0] got, exp;
    got = pack(s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_ls, s_fs);
    exp = pack(11'(h), 11'(v), hs, vs, hb, vb, ls, fs);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got h=%0d v=%0d hs/vs/hb/vb/ls/fs=%b required h=%0d v=%0d hs/vs/hb/vb/ls/fs=%b",
               nm, s_h, s_v, got[5:0], h, v, exp[5:0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, vs_c, vb_c, hs_c, hb_c;
    bit found;
    logic [27:0] got, exp;

    d_rst = 1'b0; d_en = 1'b0;
    s_rst = 1'b0; s_en = 1'b0;

    //   name          rst en n      h     v   hs vs hb vb ls fs
    add("reset",       0, 0, 2,     0,    0,  1, 1, 0, 0, 0, 0);
    add("rst_over_en", 0, 1, 1,     0,    0,  1, 1, 0, 0, 0, 0);
    add("first_pix",   1, 1, 1,     0,    0,  1, 1, 0, 0, 1, 1);
    add("second_pix",  1, 1, 1,     1,    0,  1, 1, 0, 0, 0, 0);
    add("h1023",       1, 1, 1022,  1023, 0,  1, 1, 0, 0, 0, 0);
    add("hblnk_rise",  1, 1, 1,     1024, 0,  1, 1, 1, 0, 0, 0);
    add("h1047",       1, 1, 23,    1047, 0,  1, 1, 1, 0, 0, 0);
    add("hsync_on",    1, 1, 1,     1048, 0,  0, 1, 1, 0, 0, 0);
    add("hsync_last",  1, 1, 135,   1183, 0,  0, 1, 1, 0, 0, 0);
    add("hsync_off",   1, 1, 1,     1184, 0,  1, 1, 1, 0, 0, 0);
    add("h1343",       1, 1, 159,   1343, 0,  1, 1, 1, 0, 0, 0);
    add("line_wrap",   1, 1, 1,     0,    1,  1, 1, 0, 0, 1, 0);
    add("h500_v10",    1, 1, 12596, 500,  10, 1, 1, 0, 0, 0, 0);
    add("en0_freeze",  1, 0, 7,     500,  10, 1, 1, 0, 0, 0, 0);
    add("resume",      1, 1, 1,     501,  10, 1, 1, 0, 0, 0, 0);
    add("line11",      1, 1, 843,   0,    11, 1, 1, 0, 0, 1, 0);
    add("pulse_held",  1, 0, 3,     0,    11, 1, 1, 0, 0, 1, 0);
    add("pulse_drop",  1, 1, 1,     1,    11, 1, 1, 0, 0, 0, 0);
    add("mid_reset",   0, 1, 1,     0,    0,  1, 1, 0, 0, 0, 0);
    add("restart",     1, 1, 1,     0,    0,  1, 1, 0, 0, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      d_rst = vq[i].rst;
      d_en  = vq[i].en;
      step(vq[i].n);
      got = pack(d_h, d_v, d_hs, d_vs, d_hb, d_vb, d_ls, d_fs);
      exp = pack(vq[i].h, vq[i].v, vq[i].hs, vq[i].vs,
                 vq[i].hb, vq[i].vb, vq[i].ls, vq[i].fs);
      nvec++;
      if (got !== exp) begin
        nbad++;
        $display("FAIL %s: got h=%0d v=%0d hs/vs/hb/vb/ls/fs=%b required h=%0d v=%0d hs/vs/hb/vb/ls/fs=%b",
                 vq[i].nm, d_h, d_v, got[5:0], vq[i].h, vq[i].v, exp[5:0]);
      end
    end

    // small instance: held in reset so far; syncs inactive = 0
    chk_s("s_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    s_rst = 1'b1; s_en = 1'b1;
    step(1);
    chk_s("s_first", 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("s_cnt0", int'(s_cnt), 0);
`endif

    cnt = 0; vs_c = 0; vb_c = 0; hs_c = 0; hb_c = 0; found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (s_vs) vs_c++;
      if (s_vb) vb_c++;
      if (s_hs) hs_c++;
      if (s_hb) hb_c++;
      step(1);
      cnt++;
      if (s_fs) found = 1;
    end
    chk("s_frame_period", cnt, 275);
    chk("s_vsync_cycles", vs_c, 50);
    chk("s_vblnk_cycles", vb_c, 125);
    chk("s_hsync_cycles", hs_c, 33);
    chk("s_hblnk_cycles", hb_c, 99);
    chk_s("s_frame_wrap", 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("s_cnt1", int'(s_cnt), 1);
`endif

    step(275);
    chk_s("s_frame2", 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("s_cnt2", int'(s_cnt), 2);
`endif
    step(275);
    chk_s("s_frame3", 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("s_cnt3", int'(s_cnt), 3);
`endif

    // vblank region with both syncs active
    step(194);
    chk_s("s_h19_v7", 19, 7, 1, 1, 1, 1, 0, 0);
    s_rst = 1'b0;
    step(1);
    chk_s("s_mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("s_cnt_reset", int'(s_cnt), 0);
`endif
    s_rst = 1'b1;
    step(1);
    chk_s("s_restart", 0, 0, 0, 0, 0, 0, 1, 1);
    step(1);
    chk_s("s_restart_h1", 1, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
